// File: rtl/ycbcr_pkg.sv
// Shared definitions for the YCbCr skin bounding-box stage: default widths,
// default Cb/Cr skin windows, commit FSM states and the result record.
package ycbcr_pkg;
  localparam int X_W_D   = 11;
  localparam int Y_W_D   = 10;
  localparam int CNT_W_D = 21;

  localparam logic [7:0] CB_MIN_D = 8'd77;
  localparam logic [7:0] CB_MAX_D = 8'd127;
  localparam logic [7:0] CR_MIN_D = 8'd133;
  localparam logic [7:0] CR_MAX_D = 8'd173;

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} cstate_t;

  // Result record at the default widths, for consumers of the published bbox.
  typedef struct packed {
    logic [X_W_D-1:0]   x_min;
    logic [X_W_D-1:0]   x_max;
    logic [Y_W_D-1:0]   y_min;
    logic [Y_W_D-1:0]   y_max;
    logic [CNT_W_D-1:0] cnt;
  } bbox_t;

  function automatic logic in_win(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/ycbcr_skin_bbox_classify.sv
// Per-pixel skin window compare; registers the mask and delays the timing
// signals by one cycle so they stay aligned with the mask.
module skin_classify
  import ycbcr_pkg::*;
#(
  parameter logic [7:0] CB_MIN = CB_MIN_D,
  parameter logic [7:0] CB_MAX = CB_MAX_D,
  parameter logic [7:0] CR_MIN = CR_MIN_D,
  parameter logic [7:0] CR_MAX = CR_MAX_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] ycbcr,
  input  logic        in_v,
  input  logic        in_h,
  input  logic        in_de,
  output logic        skin,
  output logic [23:0] mask,
  output logic        out_v,
  output logic        out_h,
  output logic        out_de
);
  // Luma plays no part in the decision.
  logic unused_y;
  assign unused_y = ^ycbcr[23:16];

  assign skin = in_win(ycbcr[15:8], CB_MIN, CB_MAX) && in_win(ycbcr[7:0], CR_MIN, CR_MAX);

  // One-stage mask/timing register; blanking pixels always produce a zero mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask   <= '0;
      out_v  <= 1'b0;
      out_h  <= 1'b0;
      out_de <= 1'b0;
    end else begin
      mask   <= (skin && in_de) ? 24'hFFFFFF : 24'h000000;
      out_v  <= in_v;
      out_h  <= in_h;
      out_de <= in_de;
    end
  end
endmodule

// File: rtl/ycbcr_skin_bbox.sv
// Skin mask + per-frame bounding box of skin pixels.
// Optional feature: define SKIN_BBOX_CENTER_EN to build the bbox centre
// outputs cx/cy; otherwise they are tied to 0.
module ycbcr_skin_bbox
  import ycbcr_pkg::*;
#(
  parameter int         X_W    = X_W_D,
  parameter int         Y_W    = Y_W_D,
  parameter int         CNT_W  = CNT_W_D,
  parameter logic [7:0] CB_MIN = CB_MIN_D,
  parameter logic [7:0] CB_MAX = CB_MAX_D,
  parameter logic [7:0] CR_MIN = CR_MIN_D,
  parameter logic [7:0] CR_MAX = CR_MAX_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [23:0]      YCbCr,
  input  logic             in_v,
  input  logic             in_h,
  input  logic             in_de,
  output logic [23:0]      mask,
  output logic             out_v,
  output logic             out_h,
  output logic             out_de,
  output logic [X_W-1:0]   x_min,
  output logic [X_W-1:0]   x_max,
  output logic [Y_W-1:0]   y_min,
  output logic [Y_W-1:0]   y_max,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             empty,
  output logic [X_W-1:0]   cx,
  output logic [Y_W-1:0]   cy,
  output logic             frame_done
);
  typedef struct packed {
    logic [X_W-1:0]   x_min;
    logic [X_W-1:0]   x_max;
    logic [Y_W-1:0]   y_min;
    logic [Y_W-1:0]   y_max;
    logic [CNT_W-1:0] cnt;
  } acc_t;

  localparam logic [X_W-1:0]   X_ONES = {X_W{1'b1}};
  localparam logic [Y_W-1:0]   Y_ONES = {Y_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ONES = {CNT_W{1'b1}};
  localparam acc_t ACC_INIT = '{x_min: X_ONES, x_max: '0, y_min: Y_ONES, y_max: '0, cnt: '0};

  logic           skin;
  logic           prev_v, prev_de, v_rise, de_fall, commit;
  logic [X_W-1:0] x, pos_x;
  logic [Y_W-1:0] y, pos_y;
  acc_t           acc, acc_nxt;
  cstate_t        state, state_nxt;

  skin_classify #(
    .CB_MIN(CB_MIN), .CB_MAX(CB_MAX), .CR_MIN(CR_MIN), .CR_MAX(CR_MAX)
  ) u_cls (
    .clk(clk), .rst_n(rst_n), .ycbcr(YCbCr),
    .in_v(in_v), .in_h(in_h), .in_de(in_de),
    .skin(skin), .mask(mask), .out_v(out_v), .out_h(out_h), .out_de(out_de)
  );

  assign v_rise  = in_v & ~prev_v;
  assign de_fall = prev_de & ~in_de;

  // Current pixel position and next accumulator; a frame edge restarts both
  // so a pixel coinciding with the edge lands at (0,0) of the new frame.
  always_comb begin
    pos_x   = v_rise ? '0 : x;
    pos_y   = v_rise ? '0 : y;
    acc_nxt = v_rise ? ACC_INIT : acc;
    if (in_de && skin) begin
      if (pos_x < acc_nxt.x_min) acc_nxt.x_min = pos_x;
      if (pos_x > acc_nxt.x_max) acc_nxt.x_max = pos_x;
      if (pos_y < acc_nxt.y_min) acc_nxt.y_min = pos_y;
      if (pos_y > acc_nxt.y_max) acc_nxt.y_max = pos_y;
      if (acc_nxt.cnt != C_ONES) acc_nxt.cnt = acc_nxt.cnt + CNT_W'(1);
    end
  end

  // Edge history, saturating position counters and working accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_v  <= 1'b0;
      prev_de <= 1'b0;
      x       <= '0;
      y       <= '0;
      acc     <= ACC_INIT;
    end else begin
      prev_v  <= in_v;
      prev_de <= in_de;
      acc     <= acc_nxt;
      if (in_de)       x <= (pos_x == X_ONES) ? pos_x : pos_x + X_W'(1);
      else if (de_fall) x <= '0;
      else             x <= pos_x;
      if (de_fall && pos_y != Y_ONES) y <= pos_y + Y_W'(1);
      else                            y <= pos_y;
    end
  end

  // Commit FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The first frame edge after reset only arms; later edges commit.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    if (v_rise) begin
      state_nxt = ARMED;
      commit    = (state == ARMED);
    end
  end

  // Publish the finished frame; an empty frame reports all-zero geometry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0;
      pix_cnt <= '0; empty <= 1'b0; frame_done <= 1'b0;
    end else begin
      frame_done <= commit;
      if (commit) begin
        empty <= (acc.cnt == '0);
        if (acc.cnt == '0) begin
          x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0; pix_cnt <= '0;
        end else begin
          x_min <= acc.x_min; x_max <= acc.x_max;
          y_min <= acc.y_min; y_max <= acc.y_max; pix_cnt <= acc.cnt;
        end
      end
    end
  end

`ifdef SKIN_BBOX_CENTER_EN
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  assign sum_x = {1'b0, acc.x_min} + {1'b0, acc.x_max};
  assign sum_y = {1'b0, acc.y_min} + {1'b0, acc.y_max};

  // Centre registered alongside the other frame results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx <= '0; cy <= '0;
    end else if (commit) begin
      cx <= (acc.cnt == '0) ? '0 : sum_x[X_W:1];
      cy <= (acc.cnt == '0) ? '0 : sum_y[Y_W:1];
    end
  end
`else
  assign cx = '0;
  assign cy = '0;
`endif
endmodule
